// File: rtl/data_ram_arbiter_if.sv
// CPU, host and RAM signal bundle for the data-RAM arbiter.
// slave = arbiter side; master = the surrounding CPU/host/RAM environment.
interface data_ram_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_ram_arbiter.sv
// Single-port data RAM arbiter: CPU has priority, host is served in idle CPU
// cycles, and a starvation counter forces a one-cycle CPU stall for the host.
module data_ram_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  data_ram_arbiter_if.slave   bus
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          cpu_busy, starved, host_grant;

  assign cpu_busy   = bus.cpu_rd | bus.cpu_wr;
  // Stall is purely registered so the CPU sees no input-to-stall path.
  assign starved    = (state_q == WAIT) && (wait_cnt_q == LIM);
  assign host_grant = ((state_q == IDLE || state_q == WAIT) && bus.host_req && !cpu_busy)
                      || starved;

  assign bus.cpu_stall  = starved;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.host_ack   = (state_q == ACK);
  assign bus.host_rdata = host_rdata_q;

  always_comb begin
    if (host_grant) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.host_we;
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
    end else begin
      bus.mem_en    = cpu_busy;
      bus.mem_we    = bus.cpu_wr;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    host_rdata_d = host_rdata_q;
    if (host_grant && !bus.host_we)
      host_rdata_d = bus.mem_rdata;
    case (state_q)
      IDLE: begin
        if (host_grant) begin
          state_d = ACK;
        end else if (bus.host_req && cpu_busy) begin
          state_d    = WAIT;
          wait_cnt_d = 4'd1;
        end
      end
      WAIT: begin
        // A dropped request is a legal abandon, even on the forced cycle.
        if (!bus.host_req) begin
          state_d    = IDLE;
          wait_cnt_d = 4'd0;
        end else if (host_grant) begin
          state_d    = ACK;
          wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != LIM) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ACK: begin
        state_d    = IDLE;
        wait_cnt_d = 4'd0;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 4'd0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      host_rdata_q <= host_rdata_d;
    end
  end
endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a behavioural combinational-read RAM.
module tb_data_ram_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_ram_arbiter_if #(.AW(8), .DW(8)) bus ();

  data_ram_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] ram [256] = '{default: 8'h00};
  logic       pl_en;
  logic [7:0] pl_addr, pl_data;
  int         wr_cnt = 0;

  assign bus.mem_rdata = ram[bus.mem_addr];

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (bus.mem_en && bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    cyc();
    pl_en = 1'b0;
  endtask

  int w0;

  initial begin
    reset = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
    cyc();
    preload(8'h20, 8'h3C);
    preload(8'h30, 8'h5A);
    preload(8'h40, 8'h11);
    chk("rst_ack", bus.host_ack, 0);
    chk("rst_stall", bus.cpu_stall, 0);
    chk("rst_rdata", bus.host_rdata, 0);
    reset = 1'b1;
    cyc();

    // Uncontended host write
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 8'h10; bus.host_wdata = 8'hA5;
    #1;
    chk("w_en", bus.mem_en, 1);
    chk("w_we", bus.mem_we, 1);
    chk("w_addr", bus.mem_addr, 8'h10);
    chk("w_wdata", bus.mem_wdata, 8'hA5);
    chk("w_ack0", bus.host_ack, 0);
    cyc();
    chk("w_ack1", bus.host_ack, 1);
    chk("w_ram", ram[8'h10], 8'hA5);
    chk("w_stall", bus.cpu_stall, 0);
    bus.host_req = 0;
    cyc();
    chk("w_ack_drop", bus.host_ack, 0);

    // Uncontended host read
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 8'h20;
    #1;
    chk("r_we", bus.mem_we, 0);
    chk("r_addr", bus.mem_addr, 8'h20);
    cyc();
    chk("r_ack", bus.host_ack, 1);
    chk("r_rdata", bus.host_rdata, 8'h3C);
    bus.host_req = 0;
    cyc();
    chk("r_ack_drop", bus.host_ack, 0);
    chk("r_hold", bus.host_rdata, 8'h3C);

    // Starvation: CPU reads every cycle, host read pending
    bus.cpu_rd = 1; bus.cpu_addr = 8'h40;
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 8'h30;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("s_cpu_addr%0d", i), bus.mem_addr, 8'h40);
      chk($sformatf("s_stall%0d", i), bus.cpu_stall, 0);
      chk($sformatf("s_cpu_rdata%0d", i), bus.cpu_rdata, 8'h11);
      cyc();
    end
    #1;
    chk("s_stall", bus.cpu_stall, 1);
    chk("s_host_addr", bus.mem_addr, 8'h30);
    chk("s_en", bus.mem_en, 1);
    cyc();
    chk("s_ack", bus.host_ack, 1);
    chk("s_unstall", bus.cpu_stall, 0);
    chk("s_rdata", bus.host_rdata, 8'h5A);
    chk("s_ack_cpu_addr", bus.mem_addr, 8'h40);
    bus.host_req = 0; bus.cpu_rd = 0;
    cyc();

    // CPU rd+wr together counts as a write; host waits
    bus.cpu_rd = 1; bus.cpu_wr = 1; bus.cpu_addr = 8'h05; bus.cpu_wdata = 8'h77;
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 8'h06; bus.host_wdata = 8'h99;
    #1;
    chk("rw_we", bus.mem_we, 1);
    chk("rw_addr", bus.mem_addr, 8'h05);
    chk("rw_wdata", bus.mem_wdata, 8'h77);
    cyc();
    chk("rw_ram", ram[8'h05], 8'h77);
    chk("rw_host_pending", ram[8'h06], 8'h00);
    chk("rw_wcnt", dut.wait_cnt_q, 1);
    chk("rw_noack", bus.host_ack, 0);
    bus.cpu_rd = 0; bus.cpu_wr = 0;
    #1;
    chk("rw_grant_addr", bus.mem_addr, 8'h06);
    chk("rw_grant_stall", bus.cpu_stall, 0);
    cyc();
    chk("rw_ack", bus.host_ack, 1);
    chk("rw_host_ram", ram[8'h06], 8'h99);
    bus.host_req = 0;
    cyc();

    // Reset while waiting
    bus.cpu_rd = 1; bus.cpu_addr = 8'h40;
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 8'h20;
    cyc(); cyc(); cyc();
    chk("rw3_wcnt", dut.wait_cnt_q, 3);
    chk("rw3_rdata", bus.host_rdata, 8'h5A);
    reset = 1'b0;
    cyc();
    chk("rst2_ack", bus.host_ack, 0);
    chk("rst2_stall", bus.cpu_stall, 0);
    chk("rst2_rdata", bus.host_rdata, 0);
    chk("rst2_wcnt", dut.wait_cnt_q, 0);
    reset = 1'b1; bus.cpu_rd = 0;
    #1;
    chk("rst2_grant_en", bus.mem_en, 1);
    chk("rst2_grant_addr", bus.mem_addr, 8'h20);
    cyc();
    chk("rst2_ack1", bus.host_ack, 1);
    chk("rst2_rdata1", bus.host_rdata, 8'h3C);
    bus.host_req = 0;
    cyc();

    // Request held through ACK: one access per ack
    w0 = wr_cnt;
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 8'h50; bus.host_wdata = 8'h01;
    #1;
    chk("bb_addr", bus.mem_addr, 8'h50);
    cyc();
    chk("bb_ack1", bus.host_ack, 1);
    chk("bb_ack_en", bus.mem_en, 0);
    chk("bb_ack_we", bus.mem_we, 0);
    cyc();
    chk("bb_regrant_en", bus.mem_en, 1);
    chk("bb_gap_ack", bus.host_ack, 0);
    cyc();
    chk("bb_ack2", bus.host_ack, 1);
    bus.host_req = 0;
    cyc();
    chk("bb_writes", wr_cnt - w0, 2);

    // Abandon while waiting
    w0 = wr_cnt;
    bus.cpu_rd = 1; bus.cpu_addr = 8'h40;
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 8'h60; bus.host_wdata = 8'hEE;
    cyc();
    bus.host_req = 0; bus.cpu_rd = 0;
    #1;
    chk("ab_en", bus.mem_en, 0);
    cyc();
    chk("ab_ack", bus.host_ack, 0);
    chk("ab_wcnt", dut.wait_cnt_q, 0);
    cyc();
    chk("ab_ack2", bus.host_ack, 0);
    chk("ab_ram", ram[8'h60], 8'h00);
    chk("ab_writes", wr_cnt - w0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Shares the single-port data RAM between the CPU data path and a host/loader port (debug writes, memory dumps, DMA-style fills).
- Sits between the CPU's data-RAM controls (read-strobe, store, X-register address, data bus) and the RAM.
- The CPU has priority. The host is served in idle cycles.
- A starvation counter guarantees host progress: it forces a one-cycle CPU stall.

Parameters:
- AW, 8, address width (matches X register).
- DW, 8, data width (matches dbus).
- STARVE_LIMIT, 4, host cycles denied before a forced CPU stall (range 1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- cpu_rd  in  1  CPU data-RAM read this cycle.
- cpu_wr  in  1  CPU data-RAM write this cycle.
- cpu_addr  in  AW  CPU address (xreg).
- cpu_wdata  in  DW  CPU write data (dbus).
- cpu_rdata  out  DW  read data to CPU.
- cpu_stall  out  1  CPU must hold its state this cycle.
- host_req  in  1  host access request; level, held until ack.
- host_we  in  1  1 = write, 0 = read; stable while host_req.
- host_addr  in  AW  host address; stable while host_req.
- host_wdata  in  DW  host write data; stable while host_req.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DW  read data, valid while host_ack.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable; write on rising edge.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data (combinational read).

Behaviour:
- States: IDLE, WAIT, ACK. Registers: state, wait_cnt (4 bits), host_rdata.
- Reset (reset=0 at edge):
  - state=IDLE, wait_cnt=0, host_rdata=0.
  - host_ack=0 and cpu_stall=0 from the next cycle.
  - Any in-flight host request is abandoned. It is re-arbitrated from IDLE after reset if host_req is still high.
- cpu_busy = cpu_rd | cpu_wr.
  - rd and wr both high counts as a write.
  - cpu_rd is ignored when cpu_wr=1.
- host_grant (combinational) is high when any of the following holds:
  - state=IDLE, host_req=1 and cpu_busy=0.
  - state=WAIT, host_req=1 and cpu_busy=0.
  - state=WAIT and wait_cnt==STARVE_LIMIT (forced).
- cpu_stall = (state==WAIT && wait_cnt==STARVE_LIMIT).
  - Depends on registers only; no combinational path from inputs.
- Memory mux:
  - host_grant=1: mem_en=1, mem_we=host_we, mem_addr=host_addr, mem_wdata=host_wdata.
  - Otherwise: mem_en=cpu_busy, mem_we=cpu_wr, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - mem_en=0 forces mem_we=0.
- cpu_rdata = mem_rdata at all times. It is only meaningful on a CPU-owned read cycle.
- Transitions:
  - IDLE: host_grant -> ACK. host_req & cpu_busy -> WAIT with wait_cnt=1. Otherwise stay.
  - WAIT:
    - host_req=0 -> IDLE, wait_cnt=0 (host abandon is legal).
    - host_grant -> ACK, wait_cnt=0.
    - Otherwise wait_cnt+1 (saturates at STARVE_LIMIT).
  - ACK: host_ack=1. Next state is always IDLE. host_req is ignored this cycle, so a held request is never served twice.
- Latencies:
  - Uncontended host access: grant cycle N, host_ack at N+1.
  - Contended host access: at most STARVE_LIMIT+1 cycles from request to grant.
- host_rdata:
  - Loaded from mem_rdata on the edge ending a host-granted read cycle.
  - Held otherwise; unchanged by host writes.
- host_ack: high only in ACK.
- The host may present a new request in the cycle after ACK. It is arbitrated from IDLE.

Test Plan:
- Host write uncontended: reset released, cpu idle, host_req=1 we=1 addr=0x10 wdata=0xA5 -> same cycle mem_en=1 mem_we=1 addr 0x10; next cycle host_ack=1; RAM[0x10]=0xA5; no cpu_stall.
- Host read: RAM[0x20]=0x3C, host read addr 0x20 -> host_ack one cycle after grant with host_rdata=0x3C; host_rdata holds after ack drops.
- Starvation: STARVE_LIMIT=4, cpu_rd=1 continuously, host read pending -> CPU owns mem for 4 cycles; 5th cycle cpu_stall=1 and mem_addr=host_addr; ack next cycle; cpu_stall low again.
- CPU rd+wr simultaneous with host_req: cpu_wr=cpu_rd=1 addr 0x05 data 0x77 -> RAM[0x05]=0x77, host waits (wait_cnt=1), then served first idle CPU cycle.
- Reset mid-WAIT: assert reset=0 with wait_cnt=3 -> next cycle state IDLE, host_ack=0, cpu_stall=0, host_rdata=0; host_req still high after release with cpu idle -> served normally.
- Back-to-back/abandon: host_req held through ACK -> exactly one access per ack, second access granted no earlier than the cycle after ACK; host_req dropped in WAIT -> IDLE, no ack, no RAM write.
